// File: rtl/game_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : game_counter_ctrl
//  Purpose  : NUM_CH independent game counters. Each channel has:
//             - a programmable step and direction, with modular wrap
//             - runtime win/lose limits
//             - win/lose tallies of boundary landings
//             When a tally reaches its limit (or would overflow), the channel:
//             - pulses gameover for one cycle
//             - latches the result in who
//             - restarts at its start value on the following edge
//  Ports    : clk, rst (synchronous, active-high)
//             per channel i, flattened at [i*W +: W]:
//               in : dir, en, step, init, init_value, win_limit, lose_limit
//               out: count, winner, loser, win_tally, lose_tally, gameover,
//                    who (2'b10 win, 2'b01 lose, 2'b00 none)
//  Revision : 1.0  initial multi-channel release
// ============================================================================
module game_counter_ctrl #(
  parameter int NUM_CH  = 2,
  parameter int WIDTH   = 8,
  parameter int TALLY_W = 4,
  parameter int STEP_W  = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           dir,
  input  logic [NUM_CH-1:0]           en,
  input  logic [NUM_CH*STEP_W-1:0]    step,
  input  logic [NUM_CH-1:0]           init,
  input  logic [NUM_CH*WIDTH-1:0]     init_value,
  input  logic [NUM_CH*TALLY_W-1:0]   win_limit,
  input  logic [NUM_CH*TALLY_W-1:0]   lose_limit,
  output logic [NUM_CH*WIDTH-1:0]     count,
  output logic [NUM_CH-1:0]           winner,
  output logic [NUM_CH-1:0]           loser,
  output logic [NUM_CH*TALLY_W-1:0]   win_tally,
  output logic [NUM_CH*TALLY_W-1:0]   lose_tally,
  output logic [NUM_CH-1:0]           gameover,
  output logic [NUM_CH*2-1:0]         who
);

  localparam logic [WIDTH-1:0]   c_max       = '1;
  localparam logic [TALLY_W-1:0] c_tally_one = TALLY_W'(1);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [STEP_W-1:0]  step_i;
    logic [WIDTH-1:0]   step_ext;
    logic [WIDTH-1:0]   start_val;
    logic [WIDTH-1:0]   next_val;
    logic               loaded;
    logic               ev_win;
    logic               ev_lose;
    logic               end_win;
    logic               end_lose;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [TALLY_W-1:0] win_tally_q, win_tally_d;
    logic [TALLY_W-1:0] lose_tally_q, lose_tally_d;
    logic               gameover_q, gameover_d;
    logic [1:0]         who_q, who_d;
    logic               restart_q, restart_d;

    assign step_i = step[i*STEP_W +: STEP_W];

    // The step is applied modulo 2^WIDTH, so only its low WIDTH bits matter.
    if (STEP_W >= WIDTH) begin : g_step_trunc
      assign step_ext = step_i[WIDTH-1:0];
    end else begin : g_step_zext
      assign step_ext = {{(WIDTH-STEP_W){1'b0}}, step_i};
    end

    assign start_val = dir[i] ? c_max : '0;

    always_comb begin
      count_d      = count_q;
      win_tally_d  = win_tally_q;
      lose_tally_d = lose_tally_q;
      gameover_d   = 1'b0;
      who_d        = who_q;
      restart_d    = 1'b0;
      next_val     = count_q;
      loaded       = 1'b0;
      ev_win       = 1'b0;
      ev_lose      = 1'b0;
      end_win      = 1'b0;
      end_lose     = 1'b0;

      if (restart_q) begin
        // Restart load is not a game event; tallies were cleared at game end.
        count_d = start_val;
      end else begin
        if (init[i]) begin
          next_val = init_value[i*WIDTH +: WIDTH];
          loaded   = 1'b1;
        end else if (en[i] && (step_i != '0)) begin
          next_val = dir[i] ? (count_q - step_ext) : (count_q + step_ext);
          loaded   = 1'b1;
        end
        count_d = next_val;

        ev_win  = loaded && (next_val == c_max);
        ev_lose = loaded && (next_val == '0);

        // Game ends when the incremented tally meets a non-zero limit, or
        // when the tally is saturated and would otherwise overflow.
        end_win  = ev_win &&
                   (((win_limit[i*TALLY_W +: TALLY_W] != '0) &&
                     ((win_tally_q + c_tally_one) == win_limit[i*TALLY_W +: TALLY_W])) ||
                    (win_tally_q == '1));
        end_lose = ev_lose &&
                   (((lose_limit[i*TALLY_W +: TALLY_W] != '0) &&
                     ((lose_tally_q + c_tally_one) == lose_limit[i*TALLY_W +: TALLY_W])) ||
                    (lose_tally_q == '1));

        if (end_win || end_lose) begin
          gameover_d   = 1'b1;
          who_d        = end_win ? 2'b10 : 2'b01;
          win_tally_d  = '0;
          lose_tally_d = '0;
          restart_d    = 1'b1;
        end else if (ev_win) begin
          win_tally_d  = win_tally_q + c_tally_one;
        end else if (ev_lose) begin
          lose_tally_d = lose_tally_q + c_tally_one;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        count_q      <= start_val;
        win_tally_q  <= '0;
        lose_tally_q <= '0;
        gameover_q   <= 1'b0;
        who_q        <= 2'b00;
        restart_q    <= 1'b0;
      end else begin
        count_q      <= count_d;
        win_tally_q  <= win_tally_d;
        lose_tally_q <= lose_tally_d;
        gameover_q   <= gameover_d;
        who_q        <= who_d;
        restart_q    <= restart_d;
      end
    end

    assign count[i*WIDTH +: WIDTH]        = count_q;
    assign winner[i]                      = (count_q == c_max);
    assign loser[i]                       = (count_q == '0);
    assign win_tally[i*TALLY_W +: TALLY_W]  = win_tally_q;
    assign lose_tally[i*TALLY_W +: TALLY_W] = lose_tally_q;
    assign gameover[i]                    = gameover_q;
    assign who[i*2 +: 2]                  = who_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_game_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_game_counter_ctrl
//  Purpose  : Scoreboard bench for game_counter_ctrl (NUM_CH=2, WIDTH=4,
//             TALLY_W=2, STEP_W=3). A directed opening is followed by
//             randomized traffic. An integer-level game model predicts every
//             edge, and a monitor compares the DUT against the predictions.
//  Revision : 1.0  initial release
// ============================================================================
module tb_game_counter_ctrl;

  localparam int NUM_CH  = 2;
  localparam int WIDTH   = 4;
  localparam int TALLY_W = 2;
  localparam int STEP_W  = 3;
  localparam int MAXV    = (1 << WIDTH) - 1;
  localparam int TMAXV   = (1 << TALLY_W) - 1;

  logic                      clk;
  logic                      rst;
  logic [NUM_CH-1:0]         dir, en, init;
  logic [NUM_CH*STEP_W-1:0]  step;
  logic [NUM_CH*WIDTH-1:0]   init_value;
  logic [NUM_CH*TALLY_W-1:0] win_limit, lose_limit;
  logic [NUM_CH*WIDTH-1:0]   count;
  logic [NUM_CH-1:0]         winner, loser, gameover;
  logic [NUM_CH*TALLY_W-1:0] win_tally, lose_tally;
  logic [NUM_CH*2-1:0]       who;

  game_counter_ctrl #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .TALLY_W(TALLY_W), .STEP_W(STEP_W)
  ) dut (
    .clk(clk), .rst(rst), .dir(dir), .en(en), .step(step), .init(init),
    .init_value(init_value), .win_limit(win_limit), .lose_limit(lose_limit),
    .count(count), .winner(winner), .loser(loser), .win_tally(win_tally),
    .lose_tally(lose_tally), .gameover(gameover), .who(who)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH*WIDTH-1:0]   count;
    logic [NUM_CH-1:0]         winner;
    logic [NUM_CH-1:0]         loser;
    logic [NUM_CH*TALLY_W-1:0] win_tally;
    logic [NUM_CH*TALLY_W-1:0] lose_tally;
    logic [NUM_CH-1:0]         gameover;
    logic [NUM_CH*2-1:0]       who;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Game model state per channel, held as plain integers.
  int m_cnt[NUM_CH];
  int m_wt[NUM_CH];
  int m_lt[NUM_CH];
  int m_go[NUM_CH];
  int m_who[NUM_CH];
  int m_restart[NUM_CH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
  endtask

  task automatic end_game(input int c, input int result);
    m_go[c]      = 1;
    m_who[c]     = result;
    m_wt[c]      = 0;
    m_lt[c]      = 0;
    m_restart[c] = 1;
  endtask

  // Predict the state after the coming edge from the current inputs.
  task automatic model_edge();
    exp_t e;
    for (int c = 0; c < NUM_CH; c++) begin
      int st, iv, wl, ll, nv;
      bit ld;
      st = int'(step[c*STEP_W +: STEP_W]);
      iv = int'(init_value[c*WIDTH +: WIDTH]);
      wl = int'(win_limit[c*TALLY_W +: TALLY_W]);
      ll = int'(lose_limit[c*TALLY_W +: TALLY_W]);
      if (rst) begin
        m_cnt[c] = dir[c] ? MAXV : 0;
        m_wt[c] = 0; m_lt[c] = 0; m_go[c] = 0; m_who[c] = 0; m_restart[c] = 0;
      end else if (m_restart[c] != 0) begin
        m_cnt[c] = dir[c] ? MAXV : 0;
        m_restart[c] = 0;
        m_go[c] = 0;
      end else begin
        m_go[c] = 0;
        ld = 1'b0;
        nv = m_cnt[c];
        if (init[c]) begin
          nv = iv; ld = 1'b1;
        end else if (en[c] && st != 0) begin
          nv = dir[c] ? (m_cnt[c] + (MAXV + 1) * 8 - st) % (MAXV + 1)
                      : (m_cnt[c] + st) % (MAXV + 1);
          ld = 1'b1;
        end
        m_cnt[c] = nv;
        if (ld && nv == MAXV) begin
          if ((wl != 0 && m_wt[c] + 1 == wl) || m_wt[c] + 1 > TMAXV) end_game(c, 2);
          else m_wt[c]++;
        end else if (ld && nv == 0) begin
          if ((ll != 0 && m_lt[c] + 1 == ll) || m_lt[c] + 1 > TMAXV) end_game(c, 1);
          else m_lt[c]++;
        end
      end
      e.count[c*WIDTH +: WIDTH]          = WIDTH'(m_cnt[c]);
      e.winner[c]                        = (m_cnt[c] == MAXV);
      e.loser[c]                         = (m_cnt[c] == 0);
      e.win_tally[c*TALLY_W +: TALLY_W]  = TALLY_W'(m_wt[c]);
      e.lose_tally[c*TALLY_W +: TALLY_W] = TALLY_W'(m_lt[c]);
      e.gameover[c]                      = (m_go[c] != 0);
      e.who[c*2 +: 2]                    = 2'(m_who[c]);
    end
    sb.push_back(e);
  endtask

  // One clock: predict, let the edge happen, then settle away from the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: the DUT presents fresh outputs after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("count",      32'(count),      32'(e.count));
        chk("winner",     32'(winner),     32'(e.winner));
        chk("loser",      32'(loser),      32'(e.loser));
        chk("win_tally",  32'(win_tally),  32'(e.win_tally));
        chk("lose_tally", 32'(lose_tally), 32'(e.lose_tally));
        chk("gameover",   32'(gameover),   32'(e.gameover));
        chk("who",        32'(who),        32'(e.who));
      end
    end
  end

  task automatic set_ch(input int c, input bit d, input bit e, input int st,
                        input bit in, input int iv, input int wl, input int ll);
    dir[c]  = d;
    en[c]   = e;
    init[c] = in;
    step[c*STEP_W +: STEP_W]        = STEP_W'(st);
    init_value[c*WIDTH +: WIDTH]    = WIDTH'(iv);
    win_limit[c*TALLY_W +: TALLY_W] = TALLY_W'(wl);
    lose_limit[c*TALLY_W +: TALLY_W] = TALLY_W'(ll);
  endtask

  initial begin
    int r;
    rst = 1'b1; dir = '0; en = '0; init = '0; step = '0;
    init_value = '0; win_limit = '0; lose_limit = '0;

    // Reset start values follow dir.
    set_ch(0, 1, 0, 0, 0, 0, 0, 0); set_ch(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    set_ch(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;

    // Count up by 3 with wrap; one win landing.
    set_ch(0, 0, 1, 3, 0, 0, 0, 0);
    repeat (7) tick();

    // Immediate win via init, restart ignores init, then normal counting.
    set_ch(0, 0, 0, 3, 1, 15, 1, 0);
    tick();
    tick();
    set_ch(0, 0, 1, 3, 0, 15, 1, 0);
    tick();

    // Count down by 5 from 15; lose limit 2 reached via init to 0.
    rst = 1'b1; set_ch(0, 1, 0, 5, 0, 0, 0, 2); tick(); rst = 1'b0;
    set_ch(0, 1, 1, 5, 0, 0, 0, 2);
    repeat (3) tick();
    set_ch(0, 1, 0, 5, 1, 0, 0, 2);
    tick();
    set_ch(0, 1, 0, 5, 0, 0, 0, 2);
    tick();

    // Zero step holds; init beats en.
    set_ch(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (2) tick();
    set_ch(0, 1, 1, 3, 1, 7, 0, 0);
    tick();

    // Reset on the gameover cycle cancels the restart.
    set_ch(0, 0, 0, 0, 1, 15, 1, 0);
    tick();
    rst = 1'b1; set_ch(0, 0, 0, 0, 0, 0, 0, 0); tick(); rst = 1'b0;
    tick();

    // Channel 0 builds a tally; channel 1 ends a game without disturbing it.
    set_ch(0, 0, 0, 0, 1, 15, 0, 0); tick();
    set_ch(0, 0, 0, 0, 0, 0, 0, 0);
    set_ch(1, 0, 0, 0, 1, 15, 1, 0); tick();
    set_ch(1, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 7) == 0) dir[c] = ~dir[c];
        en[c]   = ($urandom_range(0, 3) != 0);
        init[c] = ($urandom_range(0, 7) == 0);
        step[c*STEP_W +: STEP_W] = STEP_W'($urandom);
        r = int'($urandom_range(0, 2));
        init_value[c*WIDTH +: WIDTH] = (r == 0) ? WIDTH'(0) :
                                       (r == 1) ? WIDTH'(MAXV) : WIDTH'($urandom);
        if ($urandom_range(0, 31) == 0) begin
          win_limit[c*TALLY_W +: TALLY_W]  = TALLY_W'($urandom);
          lose_limit[c*TALLY_W +: TALLY_W] = TALLY_W'($urandom);
        end
      end
      tick();
    end

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/game_counter_ctrl.md
Name: game_counter_ctrl

Overview:
- Parametrised multi-channel successor to the single multi-mode game counter.
- Each channel has a programmable step, runtime win/lose limits, modular wrap, and boundary-event tallies.
- A channel reaching its limit raises a registered one-cycle gameover, latches the result, and restarts itself.
- Channels share clk/rst and are otherwise independent; ports are flattened, channel i in bits [i*W +: W].

Parameters:
- NUM_CH, 2, number of independent counter channels
- WIDTH, 8, count width per channel; MAX = 2^WIDTH-1
- TALLY_W, 4, win/lose tally and limit width per channel
- STEP_W, 3, step input width per channel

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- dir  in  NUM_CH  per channel: 0 count up, 1 count down
- en  in  NUM_CH  per channel: apply one step this cycle
- step  in  NUM_CH*STEP_W  step magnitude; 0 = hold
- init  in  NUM_CH  load init_value this cycle
- init_value  in  NUM_CH*WIDTH  value loaded on init
- win_limit  in  NUM_CH*TALLY_W  win tally that ends a game; 0 disables
- lose_limit  in  NUM_CH*TALLY_W  lose tally that ends a game; 0 disables
- count  out  NUM_CH*WIDTH  registered count
- winner  out  NUM_CH  combinational, count == MAX
- loser  out  NUM_CH  combinational, count == 0
- win_tally  out  NUM_CH*TALLY_W  registered win events this game
- lose_tally  out  NUM_CH*TALLY_W  registered lose events this game
- gameover  out  NUM_CH  registered one-cycle pulse
- who  out  NUM_CH*2  last result: 2'b10 win, 2'b01 lose, 2'b00 none

Behaviour:
- Start value: 0 if dir=0, MAX if dir=1, taken from dir sampled in that cycle.
- Reset (rst=1 at edge): count = start value; tallies 0; gameover 0; who 00; restart flag 0. rst overrides everything, including a pending restart.
- Per-channel priority at each edge when rst=0:
  1. Restart: restart flag set → count = start value; flag cleared; init/en ignored; no event.
  2. init=1 → next = init_value.
  3. en=1 and step≠0 → next = (count ± step) mod 2^WIDTH, + for dir=0, − for dir=1.
  4. Otherwise hold; no event.
- Events: only loads from init or step count as events. Reset and restart loads never do.
  - Win event: next == MAX.
  - Lose event: next == 0.
  - The two are mutually exclusive for WIDTH ≥ 1.
  - A step that wraps past a boundary without landing on it is not an event.
- Tally update at the same edge as the event: win_tally or lose_tally += 1.
  - Game end when a limit ≠ 0 and tally+1 == limit, or tally+1 overflows (tally == 2^TALLY_W-1).
  - At the game-end edge: count still takes next (the boundary value is visible for one cycle); gameover <= 1; who <= 10 (win) or 01 (lose); both tallies <= 0; restart flag set.
  - Next edge: gameover <= 0 and the restart load occurs.
- gameover is high exactly one cycle per game end. who holds until the next game end or rst.
- A dir change mid-game affects only subsequent steps and start values. count is not realigned.
- Latency: count, tallies, gameover and who are all updated at the edge where the input is sampled. winner/loser follow count combinationally.

Test Plan (WIDTH=4, TALLY_W=2, STEP_W=3, channel 0 unless stated):
- rst=1 with dir=1 → count=15, winner=1, tallies 0, gameover 0, who=00. Repeat with dir=0 → count=0, loser=1.
- dir=0, step=3, en=1, limits 0, from count=0 → 3,6,9,12,15 (win_tally=1), 2 (wrap, no event), 5.
- win_limit=1, init=1, init_value=15 → that edge: count=15, gameover=1, who=10, tallies 0; next edge: count=0 even with init=1, gameover=0; following edge resumes normal counting.
- dir=1, step=5, lose_limit=2, from 15 → 10,5,0 (lose_tally=1); init_value=0 → gameover=1, who=01; next edge count=15.
- en=1 with step=0 → count holds, no tally change. init=1 and en=1 together → init_value loaded, step ignored.
- rst asserted on the gameover cycle → reset values next edge, no restart load, gameover 0. With NUM_CH=2, channel 1 gameover leaves channel 0 count and tallies unchanged.
